// File: rtl/noc_topo_pkg.sv
// Shared NoC topology constants: port roles of a circulant node and modular neighbour lookup.
package noc_topo_pkg;

   localparam int PORTS_PER_NODE = 4;

   localparam int P_PLUS_S0  = 0;
   localparam int P_MINUS_S0 = 1;
   localparam int P_PLUS_S1  = 2;
   localparam int P_MINUS_S1 = 3;

   // step may be negative down to -(n-1); adding n first keeps the modulo non-negative
   function automatic int neighbour_node(input int node, input int step, input int n);
      return (node + n + step) % n;
   endfunction

endpackage

// File: rtl/link_skid_buffer.sv
// Two-entry elastic link buffer with registered ready; compiled only when CIRC_LINK_REG_EN is defined.
`ifdef CIRC_LINK_REG_EN
module link_skid_buffer #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_n_i,
   input  logic [W-1:0] data_i,
   input  logic         in_w_i,
   output logic         in_r_o,
   output logic [W-1:0] data_o,
   output logic         out_w_o,
   input  logic         out_r_i
);

   logic [1:0]   cnt_q, cnt_d;
   logic [W-1:0] head_q, head_d, tail_q, tail_d;
   logic         rdy_q, rdy_d;
   logic         push_s, pop_s;

   // Pop shifts the tail forward first, then a push lands in the first free slot.
   always_comb begin
      push_s = in_w_i & rdy_q;
      pop_s  = out_r_i & (cnt_q != 2'd0);
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      if (pop_s) begin
         head_d = tail_q;
         cnt_d  = cnt_q - 2'd1;
      end else begin
         cnt_d  = cnt_q;
      end
      if (push_s) begin
         if (cnt_d == 2'd0) begin
            head_d = data_i;
         end else begin
            tail_d = data_i;
         end
         cnt_d = cnt_d + 2'd1;
      end else begin
         tail_d = tail_d;
      end
      rdy_d = (cnt_d != 2'd2);
   end

   // Buffer state; reset discards any held words and withholds ready for one cycle.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q  <= 2'd0;
         head_q <= '0;
         tail_q <= '0;
         rdy_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
         rdy_q  <= rdy_d;
      end
   end

   assign data_o  = head_q;
   assign out_w_o = (cnt_q != 2'd0);
   assign in_r_o  = rdy_q;

endmodule
`endif

// File: rtl/circulant_topology.sv
// Link fabric of a circulant NoC C(N; S0, S1): combinational wiring by default,
// per-link skid buffers when CIRC_LINK_REG_EN is defined.
module circulant_topology
   import noc_topo_pkg::*;
#(
   parameter int BUS_SIZE  = 8,
   parameter int NODES_NUM = 4,
   parameter int S0        = 1,
   parameter int S1        = 2
) (
   input  logic                                         clk_i,
   input  logic                                         rst_n_i,
   input  logic [NODES_NUM*PORTS_PER_NODE*BUS_SIZE-1:0] data_i,
   input  logic [NODES_NUM*PORTS_PER_NODE-1:0]          in_w_i,
   input  logic [NODES_NUM*PORTS_PER_NODE-1:0]          out_r_i,
   output logic [NODES_NUM*PORTS_PER_NODE*BUS_SIZE-1:0] data_o,
   output logic [NODES_NUM*PORTS_PER_NODE-1:0]          out_w_o,
   output logic [NODES_NUM*PORTS_PER_NODE-1:0]          in_r_o
);

   if (NODES_NUM < 3 || S0 < 1 || S0 >= NODES_NUM || S1 < 1 || S1 >= NODES_NUM || S0 == S1) begin : g_bad_cfg
      $error("circulant_topology: illegal NODES_NUM/S0/S1 combination");
   end

   for (genvar j = 0; j < NODES_NUM; j++) begin : g_node
      for (genvar p = 0; p < PORTS_PER_NODE; p++) begin : g_port
         // A receive port on node j is fed by the opposite-sign port of the node one generator away.
         localparam int SRC_NODE =
            (p == P_PLUS_S0)  ? neighbour_node(j,  S0, NODES_NUM) :
            (p == P_MINUS_S0) ? neighbour_node(j, -S0, NODES_NUM) :
            (p == P_PLUS_S1)  ? neighbour_node(j,  S1, NODES_NUM) :
                                neighbour_node(j, -S1, NODES_NUM);
         localparam int SRC_PORT = (p % 2 == 0) ? p + 1 : p - 1;
         localparam int SRC      = SRC_NODE * PORTS_PER_NODE + SRC_PORT;
         localparam int DST      = j * PORTS_PER_NODE + p;
`ifdef CIRC_LINK_REG_EN
         link_skid_buffer #(
            .W(BUS_SIZE)
         ) u_skid (
            .clk_i   (clk_i),
            .rst_n_i (rst_n_i),
            .data_i  (data_i[SRC*BUS_SIZE +: BUS_SIZE]),
            .in_w_i  (in_w_i[SRC]),
            .in_r_o  (in_r_o[SRC]),
            .data_o  (data_o[DST*BUS_SIZE +: BUS_SIZE]),
            .out_w_o (out_w_o[DST]),
            .out_r_i (out_r_i[DST])
         );
`else
         assign data_o[DST*BUS_SIZE +: BUS_SIZE] = data_i[SRC*BUS_SIZE +: BUS_SIZE];
         assign out_w_o[DST]                     = in_w_i[SRC];
         assign in_r_o[SRC]                      = out_r_i[DST];
`endif
      end
   end

`ifndef CIRC_LINK_REG_EN
   logic unused_clk_rst_s;
   assign unused_clk_rst_s = clk_i ^ rst_n_i;
`endif

endmodule

// File: tb/tb_circulant_topology.sv
// Scoreboard bench for circulant_topology: random handshaking traffic against a
// source-lane routing model, plus directed routing/wrap (and registered-link) cases.
module tb_circulant_topology;

   localparam int N   = 4;
   localparam int S0  = 1;
   localparam int S1  = 2;
   localparam int BW  = 4;
   localparam int L   = N * 4;
   localparam int N2  = 9;
   localparam int S0B = 2;
   localparam int S1B = 3;
   localparam int BW2 = 8;
   localparam int L2  = N2 * 4;

   logic clk = 1'b0;
   logic rst_n;
   logic [L*BW-1:0]   data_i, data_o;
   logic [L-1:0]      in_w_i, out_r_i, out_w_o, in_r_o;
   logic [L2*BW2-1:0] b_data_i, b_data_o, b_exp_d;
   logic [L2-1:0]     b_in_w_i, b_out_r_i, b_out_w_o, b_in_r_o;

   int checks   = 0;
   int failures = 0;
   logic          sb_en = 1'b0;
   logic          tx_v [L];
   logic [BW-1:0] tx_d [L];
   logic [BW-1:0] exp_q [L][$];
   logic [BW-1:0] ref_q [$];

   circulant_topology #(.BUS_SIZE(BW), .NODES_NUM(N), .S0(S0), .S1(S1)) dut_a (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(data_i), .in_w_i(in_w_i), .out_r_i(out_r_i),
      .data_o(data_o), .out_w_o(out_w_o), .in_r_o(in_r_o));

   circulant_topology #(.BUS_SIZE(BW2), .NODES_NUM(N2), .S0(S0B), .S1(S1B)) dut_b (
      .clk_i(clk), .rst_n_i(rst_n), .data_i(b_data_i), .in_w_i(b_in_w_i), .out_r_i(b_out_r_i),
      .data_o(b_data_o), .out_w_o(b_out_w_o), .in_r_o(b_in_r_o));

   always #5 clk = ~clk;

   // Where a word transmitted on source lane s ends up: +S goes to the node S ahead,
   // arriving on its -S port, and vice versa.
   function automatic int dest_lane(input int s, input int n, input int g0, input int g1);
      int node, step, dp;
      node = s / 4;
      case (s % 4)
         0:       begin step = g0;     dp = 1; end
         1:       begin step = n - g0; dp = 0; end
         2:       begin step = g1;     dp = 3; end
         default: begin step = n - g1; dp = 2; end
      endcase
      return ((node + step) % n) * 4 + dp;
   endfunction

   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive_a();
      for (int s = 0; s < L; s++) begin
         in_w_i[s]           = tx_v[s];
         data_i[s*BW +: BW]  = tx_d[s];
      end
   endtask

   // Receiver side of the scoreboard: every completed transfer must match the oldest expected word.
   always @(negedge clk) begin
      if (sb_en) begin
         #2;
         for (int d = 0; d < L; d++) begin
            if (out_w_o[d] && out_r_i[d]) begin
               if (exp_q[d].size() == 0) begin
                  check("sb_unexpected_word", {24'd0, 8'(d)}, 32'hFFFF_FFFF);
               end else begin
                  check("sb_data", data_o[d*BW +: BW], exp_q[d].pop_front());
               end
            end
         end
      end
   end

   initial begin
      logic [31:0] rnd;
      int          leftover, dk, sk;
      logic [L-1:0] exp_w, exp_r;

      for (int s = 0; s < L; s++) begin tx_v[s] = 1'b0; tx_d[s] = '0; end
      rst_n = 1'b0; data_i = '0; in_w_i = '0; out_r_i = '0;
      b_data_i = '0; b_in_w_i = '0; b_out_r_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_out_w", out_w_o, '0);
      check("reset_data", data_o, '0);
      check("reset_in_r", in_r_o, '0);
      @(posedge clk); #1;
      rst_n = 1'b1;

`ifndef CIRC_LINK_REG_EN
      data_i[3:0] = 4'hF; in_w_i = 16'h0001;
      #1;
      check("lane0_data", data_o, 64'h0000_0000_00F0_0000);
      check("lane0_valid", out_w_o, 16'h0020);
      check("lane0_ready_idle", in_r_o, 16'h0000);
      data_i = '0; in_w_i = '0; out_r_i = 16'h0001;
      #1;
      check("ready0_back", in_r_o, 16'h0020);
      check("ready0_data", data_o, '0);
      check("ready0_valid", out_w_o, '0);
      out_r_i = '0;

      for (int k = 0; k < L2; k++) begin
         dk = dest_lane(k, N2, S0B, S1B);
         sk = -1;
         for (int s = 0; s < L2; s++) if (dest_lane(s, N2, S0B, S1B) == k) sk = s;
         b_data_i = '0; b_data_i[k*BW2 +: BW2] = 8'hA5;
         b_in_w_i = '0; b_in_w_i[k] = 1'b1;
         b_out_r_i = '0; b_out_r_i[k] = 1'b1;
         #1;
         b_exp_d = '0; b_exp_d[dk*BW2 +: BW2] = 8'hA5;
         check("b_walk_data", b_data_o, b_exp_d);
         check("b_walk_valid", b_out_w_o, 36'd1 << dk);
         check("b_walk_ready", b_in_r_o, (sk < 0) ? 36'd0 : (36'd1 << sk));
      end
      b_data_i = '0; b_in_w_i = 36'd1 << 3; b_out_r_i = 36'd1 << 26;
      #1;
      check("b_n0p3_to_n6p2", b_out_w_o, 36'h0_0400_0000);
      check("b_ready_26_to_3", b_in_r_o, 36'h0_0000_0008);
      b_in_w_i = 36'd1 << 1; b_out_r_i = '0;
      #1;
      check("b_wrap_n0p1_to_n7p0", b_out_w_o, 36'd1 << 28);
      b_in_w_i = '0;
`else
      @(posedge clk); #1;
      tx_v[0] = 1'b1; tx_d[0] = 4'hF; drive_a(); out_r_i = '0;
      @(negedge clk);
      check("reg_not_same_cycle", out_w_o, '0);
      check("reg_ready_after_reset", in_r_o[0], 1'b1);
      tx_v[0] = 1'b0;
      @(posedge clk); #1; drive_a();
      @(negedge clk);
      check("reg_latency_valid", out_w_o, 16'h0020);
      check("reg_latency_data", data_o, 64'h0000_0000_00F0_0000);
      ref_q.push_back(4'hF);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         if (!tx_v[0]) begin tx_v[0] = 1'b1; tx_d[0] = 4'(c + 1); end
         drive_a();
         @(negedge clk);
         if (in_r_o[0]) begin ref_q.push_back(tx_d[0]); tx_v[0] = 1'b0; end
      end
      check("reg_full_ready_low", in_r_o[0], 1'b0);
      check("reg_two_accepted", ref_q.size(), 2);
      check("reg_data_held", data_o[23:20], 4'hF);
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         drive_a(); out_r_i = 16'h0020;
         @(negedge clk);
         if (out_w_o[5]) begin
            if (ref_q.size() == 0) check("reg_extra_word", 1'b1, 1'b0);
            else check("reg_order", data_o[23:20], ref_q.pop_front());
         end
         if (tx_v[0] && in_r_o[0]) begin ref_q.push_back(tx_d[0]); tx_v[0] = 1'b0; end
      end
      check("reg_no_loss", ref_q.size(), 0);
      check("reg_tx_drained", tx_v[0], 1'b0);
      @(posedge clk); #1;
      tx_v[0] = 1'b1; tx_d[0] = 4'h9; drive_a(); out_r_i = '0;
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("reg_midreset_valid", out_w_o, '0);
      check("reg_midreset_ready", in_r_o, '0);
      tx_v[0] = 1'b0; drive_a();
      @(posedge clk); #1; rst_n = 1'b1;
`endif

      sb_en = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         for (int s = 0; s < L; s++) begin
            if (!tx_v[s] && cyc < 360 && $urandom_range(0, 2) != 0) begin
               rnd = $urandom; tx_v[s] = 1'b1; tx_d[s] = rnd[BW-1:0];
            end
         end
         drive_a();
         rnd = $urandom;
         out_r_i = (cyc < 360) ? rnd[L-1:0] : '1;
         @(negedge clk);
`ifndef CIRC_LINK_REG_EN
         exp_w = '0; exp_r = '0;
         for (int s = 0; s < L; s++) begin
            if (tx_v[s]) exp_w[dest_lane(s, N, S0, S1)] = 1'b1;
            exp_r[s] = out_r_i[dest_lane(s, N, S0, S1)];
         end
         check("rand_fwd_valid", out_w_o, exp_w);
         check("rand_bwd_ready", in_r_o, exp_r);
`endif
         for (int s = 0; s < L; s++) begin
            if (tx_v[s] && in_r_o[s]) begin
               exp_q[dest_lane(s, N, S0, S1)].push_back(tx_d[s]);
               tx_v[s] = 1'b0;
            end
         end
      end
      @(negedge clk); #3;
      sb_en = 1'b0;
      leftover = 0;
      for (int d = 0; d < L; d++) leftover += exp_q[d].size();
      for (int s = 0; s < L; s++) if (tx_v[s]) leftover++;
      check("drain_empty", leftover, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
